// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/grant encodings and the default SRAM access time
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;
    localparam logic GNT_IF   = 1'b0;
    localparam logic GNT_DATA = 1'b1;
    localparam int WAIT_CYCLES_DEF = 4;
endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// mem_arbiter_wait_counter: loadable 4-bit down-counter with zero flag
module mem_arbiter_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);
    logic [3:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (load) r_cnt <= load_val;
        else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
    assign zero = (r_cnt == 4'd0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port SRAM between instruction fetch and the MEM stage
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_we,
    output logic              sram_oe
);
    state_t r_state, w_next;
    logic r_gnt, r_last_data;
    logic w_data_req, w_gnt, w_start, w_zero, w_is_st;
    assign w_data_req = mem_r_en | mem_w_en;
    // A data request yields to a waiting fetch right after a data grant so fetch cannot starve
    assign w_gnt   = (w_data_req & ~(if_req & r_last_data)) ? GNT_DATA : GNT_IF;
    assign w_start = (r_state == IDLE) & (if_req | w_data_req);
    assign w_is_st = (w_gnt == GNT_DATA) & mem_w_en;
    assign freeze  = (w_data_req & ~mem_ready) | (if_req & ~if_ready);
    mem_arbiter_wait_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_start),
        .load_val (4'(WAIT_CYCLES - 1)),
        .zero     (w_zero)
    );
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE)   ? (w_start ? ACCESS : IDLE) :
                 (r_state == ACCESS) ? (w_zero ? DONE : ACCESS) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt       <= GNT_IF;
            r_last_data <= 1'b0;
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            sram_we     <= 1'b0;
            sram_oe     <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if (w_start) begin
                r_gnt       <= w_gnt;
                r_last_data <= (w_gnt == GNT_DATA);
                sram_addr   <= (w_gnt == GNT_DATA) ? mem_addr : if_addr;
                sram_wdata  <= mem_wdata;
                sram_we     <= w_is_st;
                sram_oe     <= ~w_is_st;
            end
            if (r_state == ACCESS && w_zero) begin
                sram_we <= 1'b0;
                sram_oe <= 1'b0;
                if (r_gnt == GNT_DATA) mem_ready <= 1'b1;
                else if_ready <= 1'b1;
                if (sram_oe && r_gnt == GNT_DATA) mem_rdata <= sram_rdata;
                if (sram_oe && r_gnt == GNT_IF) if_rdata <= sram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven fetch/store sequence plus hand-written arbitration, withdraw, reset and WAIT_CYCLES=1 cases
module tb_mem_arbiter;
    localparam logic H = 1'b1, L = 1'b0;
    localparam logic [31:0] DB = 32'hDEADBEEF, CF = 32'hCAFEF00D, WD = 32'h12345678;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic if_req = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [17:0] if_addr = 18'h00010, mem_addr = 18'h00020;
    logic [31:0] mem_wdata = WD, sram_rdata = 32'h0;
    logic [31:0] if_rdata, mem_rdata, sram_wdata;
    logic if_ready, mem_ready, freeze, sram_we, sram_oe;
    logic [17:0] sram_addr;
    logic d1_if_req = 1'b0, d1_r = 1'b0, d1_w = 1'b0;
    logic [31:0] d1_if_rdata, d1_mem_rdata, d1_sram_wdata;
    logic d1_if_ready, d1_mem_ready, d1_freeze, d1_sram_we, d1_sram_oe;
    logic [17:0] d1_sram_addr;
    int n_chk = 0, n_fail = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we(sram_we), .sram_oe(sram_oe)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .if_req(d1_if_req), .if_addr(if_addr), .if_rdata(d1_if_rdata),
        .if_ready(d1_if_ready), .mem_r_en(d1_r), .mem_w_en(d1_w), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(d1_mem_rdata), .mem_ready(d1_mem_ready), .freeze(d1_freeze),
        .sram_addr(d1_sram_addr), .sram_wdata(d1_sram_wdata), .sram_rdata(sram_rdata),
        .sram_we(d1_sram_we), .sram_oe(d1_sram_oe)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ifq, r, w;
        logic [31:0] rd;
        logic        frz, ifr, mr, oe, we;
        logic [17:0] addr;
        logic [31:0] if_rd, mem_rd;
    } vec_t;
    vec_t tbl[13];

    initial begin
        // lone fetch (cycles 0-5), then lone store (cycles 6-11), then quiet
        tbl[0]  = '{H, L, L, DB, H, L, L, L, L, 18'h0,  32'h0, 32'h0};
        tbl[1]  = '{H, L, L, DB, H, L, L, H, L, 18'h10, 32'h0, 32'h0};
        tbl[2]  = '{H, L, L, DB, H, L, L, H, L, 18'h10, 32'h0, 32'h0};
        tbl[3]  = '{H, L, L, DB, H, L, L, H, L, 18'h10, 32'h0, 32'h0};
        tbl[4]  = '{H, L, L, DB, H, L, L, H, L, 18'h10, 32'h0, 32'h0};
        tbl[5]  = '{H, L, L, DB, L, H, L, L, L, 18'h0,  DB,    32'h0};
        tbl[6]  = '{L, L, H, CF, H, L, L, L, L, 18'h0,  DB,    32'h0};
        tbl[7]  = '{L, L, H, CF, H, L, L, L, H, 18'h20, DB,    32'h0};
        tbl[8]  = '{L, L, H, CF, H, L, L, L, H, 18'h20, DB,    32'h0};
        tbl[9]  = '{L, L, H, CF, H, L, L, L, H, 18'h20, DB,    32'h0};
        tbl[10] = '{L, L, H, CF, H, L, L, L, H, 18'h20, DB,    32'h0};
        tbl[11] = '{L, L, H, CF, L, L, H, L, L, 18'h0,  DB,    32'h0};
        tbl[12] = '{L, L, L, CF, L, L, L, L, L, 18'h0,  DB,    32'h0};

        repeat (2) @(posedge clk);
        #2;
        chkb("rst if_ready", if_ready, L);
        chkb("rst mem_ready", mem_ready, L);
        chkb("rst sram_we", sram_we, L);
        chkb("rst sram_oe", sram_oe, L);
        chkb("rst freeze", freeze, L);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst mem_rdata", mem_rdata, 32'h0);
        chk("rst sram_addr", 32'(sram_addr), 32'h0);
        chk("rst sram_wdata", sram_wdata, 32'h0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            if_req = tbl[i].ifq; mem_r_en = tbl[i].r; mem_w_en = tbl[i].w; sram_rdata = tbl[i].rd;
            #1;
            chkb($sformatf("tbl%0d freeze", i), freeze, tbl[i].frz);
            chkb($sformatf("tbl%0d if_ready", i), if_ready, tbl[i].ifr);
            chkb($sformatf("tbl%0d mem_ready", i), mem_ready, tbl[i].mr);
            chkb($sformatf("tbl%0d sram_oe", i), sram_oe, tbl[i].oe);
            chkb($sformatf("tbl%0d sram_we", i), sram_we, tbl[i].we);
            chk($sformatf("tbl%0d if_rdata", i), if_rdata, tbl[i].if_rd);
            chk($sformatf("tbl%0d mem_rdata", i), mem_rdata, tbl[i].mem_rd);
            if (tbl[i].oe | tbl[i].we) chk($sformatf("tbl%0d sram_addr", i), 32'(sram_addr), 32'(tbl[i].addr));
            if (tbl[i].we) chk($sformatf("tbl%0d sram_wdata", i), sram_wdata, WD);
            step();
        end

        // both sides held from reset: DATA, IF, DATA, IF
        if_req = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0; sram_rdata = 32'h11111111;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            #1;
            chkb($sformatf("alt c%0d mem_ready", c), mem_ready, (c == 5 || c == 17));
            chkb($sformatf("alt c%0d if_ready", c), if_ready, (c == 11 || c == 23));
            if (c == 2 || c == 14) chk($sformatf("alt c%0d addr", c), 32'(sram_addr), 32'h20);
            if (c == 8 || c == 20) chk($sformatf("alt c%0d addr", c), 32'(sram_addr), 32'h10);
            step();
        end

        // LD withdrawn in cycle 2 still completes
        if_req = 1'b0; mem_r_en = 1'b1; sram_rdata = 32'hA1B2C3D4;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c == 2) mem_r_en = 1'b0;
            #1;
            chkb($sformatf("wd c%0d mem_ready", c), mem_ready, c == 5);
            chkb($sformatf("wd c%0d sram_oe", c), sram_oe, c >= 1 && c <= 4);
            if (c >= 2) chkb($sformatf("wd c%0d freeze", c), freeze, L);
            if (c == 5) chk("wd mem_rdata", mem_rdata, 32'hA1B2C3D4);
            step();
        end

        // reset in the 2nd ACCESS cycle of a store, then a fresh LD
        mem_w_en = 1'b1;
        do_reset();
        step();
        step();
        #1;
        chkb("rs access2 sram_we", sram_we, H);
        rst = 1'b1;
        step();
        rst = 1'b0; mem_w_en = 1'b0; mem_r_en = 1'b1; sram_rdata = 32'h55AA55AA;
        #1;
        chkb("rs after sram_we", sram_we, L);
        chk("rs after mem_rdata", mem_rdata, 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) #1;
            chkb($sformatf("rs k%0d mem_ready", k), mem_ready, k == 5);
            if (k == 5) chk("rs ld mem_rdata", mem_rdata, 32'h55AA55AA);
            step();
        end
        mem_r_en = 1'b0;

        // WAIT_CYCLES=1 instance: back-to-back LDs, then LD+ST together
        d1_r = 1'b1; sram_rdata = 32'h0F0F0F0F;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c == 6) d1_w = 1'b1;
            #1;
            chkb($sformatf("w1 c%0d mem_ready", c), d1_mem_ready, (c == 2 || c == 5 || c == 8));
            if (c == 1 || c == 4) chkb($sformatf("w1 c%0d sram_oe", c), d1_sram_oe, H);
            if (c == 7) chkb("w1 both sram_we", d1_sram_we, H);
            if (c == 7) chkb("w1 both sram_oe", d1_sram_oe, L);
            if (c == 2) chk("w1 mem_rdata", d1_mem_rdata, 32'h0F0F0F0F);
            step();
        end
        d1_r = 1'b0; d1_w = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
